// File: rtl/mem_stage.sv
// MEM stage: passes ALU results through and serialises loads/stores over a
// byte-wide, little-endian memory port, stalling the pipeline until done.
module mem_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            ex_wd,
  input  logic                  ex_wreg,
  input  logic [31:0]           ex_wdata,
  input  logic                  ex_mem_en,
  input  logic                  ex_mem_we,
  input  logic [2:0]            ex_funct3,
  input  logic [ADDR_WIDTH-1:0] ex_mem_addr,
  input  logic [31:0]           ex_store_data,
  output logic [4:0]            mem_wd,
  output logic                  mem_wreg,
  output logic [31:0]           mem_wdata,
  output logic                  stallreq,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_wbyte,
  input  logic                  ram_ack,
  input  logic [7:0]            ram_rbyte
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic [31:0] load_buf, load_buf_next;
  logic [1:0]  last_idx;
  logic [31:0] load_ext;

  // Index of the final byte; the unused size codes fall back to a full word.
  always_comb begin
    case (ex_funct3[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  always_comb begin
    case (ex_funct3)
      3'b000:  load_ext = {{24{load_buf[7]}}, load_buf[7:0]};
      3'b001:  load_ext = {{16{load_buf[15]}}, load_buf[15:0]};
      3'b100:  load_ext = {24'd0, load_buf[7:0]};
      3'b101:  load_ext = {16'd0, load_buf[15:0]};
      default: load_ext = load_buf;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      load_buf <= 32'd0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      load_buf <= load_buf_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    load_buf_next = load_buf;
    case (state)
      IDLE: begin
        if (ex_mem_en) begin
          state_next = BUSY;
          cnt_next   = 2'd0;
        end
      end
      BUSY: begin
        if (ram_ack) begin
          if (!ex_mem_we)
            load_buf_next[{cnt, 3'b000} +: 8] = ram_rbyte;
          if (cnt == last_idx)
            state_next = DONE;
          else
            cnt_next = cnt + 2'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced quiet during reset so an abandoned access drops at once.
  always_comb begin
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    mem_wdata = ex_wdata;
    stallreq  = 1'b0;
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wbyte = 8'd0;
    if (!rst) begin
      mem_wd    = 5'd0;
      mem_wreg  = 1'b0;
      mem_wdata = 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_mem_en) begin
            stallreq = 1'b1;
            mem_wreg = 1'b0;
          end
        end
        BUSY: begin
          stallreq  = 1'b1;
          mem_wreg  = 1'b0;
          ram_req   = 1'b1;
          ram_we    = ex_mem_we;
          ram_addr  = ex_mem_addr + ADDR_WIDTH'(cnt);
          ram_wbyte = ex_store_data[{cnt, 3'b000} +: 8];
        end
        DONE: begin
          if (ex_mem_we)
            mem_wreg = 1'b0;
          else
            mem_wdata = load_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random loads/stores against a byte-level
// reference model, with an inline memory responder driven from each task.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_mem_en;
  logic        ex_mem_we;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wbyte;
  logic        ram_ack;
  logic [7:0]  ram_rbyte;

  int vectors = 0;
  int miscompares = 0;

  mem_stage #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_mem_en(ex_mem_en), .ex_mem_we(ex_mem_we), .ex_funct3(ex_funct3),
    .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stallreq(stallreq), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wbyte(ram_wbyte),
    .ram_ack(ram_ack), .ram_rbyte(ram_rbyte)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int model_bytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  // Bytes arrive little-endian in rb; extension done with plain arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] rb);
    logic [31:0] b, h;
    b = rb & 32'hFF;
    h = rb & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b + 32'hFFFFFF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rb;
    endcase
  endfunction

  // One complete memory op: IDLE detect, every byte (with waits), then DONE.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rb,
                       input int delay, input logic spur_done);
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata, ea, exp_data;
    logic [41:0] obs_b, exp_b;
    logic [39:0] obs_d, exp_d;
    int n;
    @(negedge clk);
    wd = 5'($urandom); wreg = 1'($urandom); wdata = $urandom;
    ex_mem_en = 1'b1; ex_mem_we = we; ex_funct3 = f3; ex_mem_addr = addr;
    ex_store_data = sdata; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ram_ack = 1'b0; ram_rbyte = 8'($urandom);
    #1;
    vectors++;
    if ({ram_req, stallreq, mem_wreg} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL op_detect got req/stall/wreg=%b want 010", {ram_req, stallreq, mem_wreg});
    end
    n = model_bytes(f3);
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w <= delay; w++) begin
        @(negedge clk);
        ram_ack = (w == delay);
        ram_rbyte = ram_ack ? rb[8*i +: 8] : 8'($urandom);
        #1;
        ea = addr + 32'(i);
        exp_b = {1'b1, we, ea, sdata[8*i +: 8], 1'b1, 1'b0};
        obs_b = {ram_req, ram_we, ram_addr, ram_wbyte, stallreq, mem_wreg};
        vectors++;
        if (obs_b !== exp_b) begin
          miscompares++;
          $display("[TB] FAIL op_byte%0d_wait%0d got %h want %h", i, w, obs_b, exp_b);
        end
      end
    end
    @(negedge clk);
    ram_ack = spur_done;
    ram_rbyte = 8'($urandom);
    #1;
    exp_data = we ? wdata : model_load(f3, rb);
    exp_d = {1'b0, 1'b0, wd, we ? 1'b0 : wreg, exp_data};
    obs_d = {ram_req, stallreq, mem_wd, mem_wreg, mem_wdata};
    vectors++;
    if (obs_d !== exp_d) begin
      miscompares++;
      $display("[TB] FAIL op_done f3=%0d got %h want %h", f3, obs_d, exp_d);
    end
  endtask

  task automatic test_reset();
    logic [43:0] obs;
    rst = 1'b0; ram_ack = 1'b0; ram_rbyte = 8'h00;
    ex_mem_en = 1'b0; ex_mem_we = 1'b0; ex_funct3 = 3'b010;
    ex_mem_addr = $urandom; ex_store_data = $urandom;
    ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    #1;
    obs = {mem_wd, mem_wreg, mem_wdata, stallreq, ram_req, ram_we, ram_wbyte[2:0]};
    vectors++;
    if (obs !== 44'd0 || ram_addr !== 32'd0 || ram_wbyte !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got %h addr %h want all zero", obs, ram_addr);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_passthrough();
    logic [39:0] obs, exp;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ex_mem_en = 1'b0;
      ram_ack = (k == 3);
      if (k == 0) begin
        ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234;
      end else begin
        ex_wd = 5'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
      end
      #1;
      exp = {ex_wd, ex_wreg, ex_wdata, 1'b0, 1'b0};
      obs = {mem_wd, mem_wreg, mem_wdata, stallreq, ram_req};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL passthrough%0d got %h want %h", k, obs, exp);
      end
    end
    ram_ack = 1'b0;
  endtask

  task automatic test_lw();
    do_op(1'b0, 3'b010, 32'h100, $urandom, 32'h12345678, 0, 1'b0);
  endtask

  task automatic test_sign_ext();
    do_op(1'b0, 3'b000, 32'h200, $urandom, 32'h00000080, 0, 1'b0);
    do_op(1'b0, 3'b100, 32'h201, $urandom, 32'h00000080, 0, 1'b0);
    do_op(1'b0, 3'b001, 32'h202, $urandom, 32'h00009000, 0, 1'b0);
    do_op(1'b0, 3'b101, 32'h204, $urandom, 32'h0000F00D, 1, 1'b0);
  endtask

  task automatic test_sh_wrap();
    do_op(1'b1, 3'b001, 32'hFFFFFFFF, 32'hAABBCCDD, $urandom, 3, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    logic [40:0] obs;
    @(negedge clk);
    ex_mem_en = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'b010;
    ex_mem_addr = 32'h300; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = $urandom;
    @(negedge clk);
    ram_ack = 1'b1; ram_rbyte = 8'h11;
    @(negedge clk);
    ram_ack = 1'b0;
    #1;
    vectors++;
    if (ram_req !== 1'b1 || ram_addr !== 32'h301) begin
      miscompares++;
      $display("[TB] FAIL midreset_byte1 got req=%b addr=%h want 1 00000301", ram_req, ram_addr);
    end
    #1 rst = 1'b0;
    #1;
    obs = {ram_req, stallreq, mem_wd, mem_wreg, mem_wdata, ram_we};
    vectors++;
    if (obs !== 41'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_async got %h want 0", obs);
    end
    ex_mem_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({ram_req, stallreq, mem_wd} !== {2'b00, ex_wd}) begin
      miscompares++;
      $display("[TB] FAIL midreset_idle got %h want %h", {ram_req, stallreq, mem_wd}, {2'b00, ex_wd});
    end
    do_op(1'b0, 3'b000, 32'h400, $urandom, 32'h0000007F, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 3'b010, 32'h500, $urandom, 32'hCAFEF00D, 0, 1'b1);
    do_op(1'b1, 3'b000, 32'h600, 32'h000000A5, $urandom, 1, 1'b1);
    do_op(1'b0, 3'b101, 32'h700, $urandom, 32'h0000BEEF, 0, 1'b0);
  endtask

  task automatic test_random_ops();
    logic [2:0] codes [5];
    codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int k = 0; k < 25; k++) begin
      do_op(1'($urandom), codes[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
            int'($urandom_range(0, 2)), 1'($urandom));
    end
    @(negedge clk);
    ram_ack = 1'b0;
    ex_mem_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_sign_ext();
    test_sh_wrap();
    test_reset_mid_access();
    test_back_to_back();
    test_random_ops();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
